apb_mem_slave: RTL

APB completer, downstream of the APB bridge/master in the 2-slave subsystem. Each of the master's two PSELx lines drives one instance. Holds a word-addressed register memory and inserts a fixed number of wait states per transfer via PREADY. Flags out-of-range accesses with PSLVERR.

---
 rtl/apb_mem_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer holding DEPTH words of DW-bit register memory.
// Every transfer gets WAIT_CYCLES wait states before pready. Misaligned and
// out-of-range accesses complete with pslverr=1.
// Optional build macro APB_SLV_PSTRB_EN adds the pstrb byte-strobe input.
// The strobe masks write bytes. A read with a non-zero strobe is errored.
module apb_mem_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr
`ifdef APB_SLV_PSTRB_EN
    ,
    input  logic [DW/8-1:0] pstrb
`endif
);

    localparam int NB   = DW / 8;
    localparam int IDXW = AW - 2;
    localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0] DEPTH_IDX = IDXW'(DEPTH);
    localparam logic [3:0]      WAIT_LD   = 4'(WAIT_CYCLES);

    // The setup phase is any cycle in IDLE, or in the completing ACCESS cycle,
    // where psel=1 and penable=0. Address and control are captured at the
    // closing edge of that cycle. The transfer therefore takes 2+WAIT_CYCLES
    // cycles and can follow the previous completion without a gap.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1
    } state_t;

    state_t          state_reg;
    logic [3:0]      cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic            write_reg;
    logic [DW-1:0]   wdata_reg;
    logic [DW-1:0]   mem [DEPTH];

    logic [IDXW-1:0] idx;
    logic            addr_err;
    logic            strb_err;
    logic            err;
    logic            done;
    logic            setup_req;
    logic            load;
    logic            commit;
    logic [NB-1:0]   byte_en;
    logic [DW-1:0]   wmask;

    assign idx       = addr_reg[AW-1:2];
    assign addr_err  = (idx >= DEPTH_IDX) || (addr_reg[1:0] != 2'b00);
    assign err       = addr_err || strb_err;
    assign done      = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    assign setup_req = psel && !penable;
    assign load      = ((state_reg == IDLE) || done) && setup_req;
    // A dropped psel/penable on the last cycle counts as an abort, so no write
    // is made.
    assign commit    = done && psel && penable && write_reg && !err;

    assign pready    = done;
    assign pslverr   = done && err;
    assign prdata    = (done && !write_reg && !err) ? mem[idx[MW-1:0]] : '0;

`ifdef APB_SLV_PSTRB_EN
    logic [NB-1:0] strb_reg;

    // Capture the byte strobe together with the rest of the setup phase.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            strb_reg <= '0;
        end else if (load) begin
            strb_reg <= pstrb;
        end
    end

    assign byte_en  = strb_reg;
    assign strb_err = !write_reg && (strb_reg != '0);
`else
    assign byte_en  = '1;
    assign strb_err = 1'b0;
`endif

    // Expand the per-byte enables into a bit mask for the read-modify-write.
    for (genvar gi = 0; gi < NB; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{byte_en[gi]}};
    end

    // Capture address, direction and write data at the end of the setup phase.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else if (load) begin
            addr_reg  <= paddr;
            write_reg <= pwrite;
            wdata_reg <= pwdata;
        end
    end

    // Transfer FSM. ACCESS counts down the wait states. An abort returns to IDLE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        state_reg <= ACCESS;
                        cnt_reg   <= WAIT_LD;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        if (load) begin
                            state_reg <= ACCESS;
                            cnt_reg   <= WAIT_LD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (!psel || !penable) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 4'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    // Word memory. It is cleared by reset and written byte-masked on completion.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx[MW-1:0]] <= (mem[idx[MW-1:0]] & ~wmask) | (wdata_reg & wmask);
        end
    end

endmodule
